// File: rtl/jk_seq_ctrl.sv
// Command sequencer for a bank of J-K flip-flops: computes J/K excitation toward
// the target state of each step and applies it to the internally held bank.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | one excitation step per clock, remaining counts down to 1
// DONE  | one-cycle completion pulse before returning to IDLE
module jk_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_rpt,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_INC    = 3'b010;
  localparam logic [2:0] OP_DEC    = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_CLEAR  = 3'b101;
  localparam logic [2:0] OP_SHIFTL = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   tgt;
  logic               accept;
  logic               run;
  logic               wrap_nxt;

  assign run    = (state == RUN);
  assign accept = cmd_valid & cmd_ready;
  assign busy   = (state != IDLE);
  assign Q      = q_r;

  always_comb begin
    tgt = q_r;
    unique case (op_q)
      OP_HOLD:   tgt = q_r;
      OP_LOAD:   tgt = data_q;
      OP_INC:    tgt = q_r + WIDTH'(1);
      OP_DEC:    tgt = q_r - WIDTH'(1);
      OP_TOGGLE: tgt = q_r ^ data_q;
      OP_CLEAR:  tgt = '0;
      OP_SHIFTL: tgt = {q_r[WIDTH-2:0], data_q[0]};
      OP_RSVD:   tgt = q_r;
    endcase
  end

  // Excitation is forced to hold outside RUN so an external bank stays put.
  assign J = run ? (tgt & ~q_r) : '0;
  assign K = run ? (~tgt & q_r) : '0;

  assign wrap_nxt = run & (((op_q == OP_INC) & (&q_r)) | ((op_q == OP_DEC) & ~(|q_r)));

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    cmd_ready     = 1'b0;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = Rst;
        if (accept) begin
          state_nxt     = RUN;
          remaining_nxt = (cmd_rpt == '0) ? CNT_W'(1) : cmd_rpt;
        end
      end
      RUN: begin
        remaining_nxt = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      remaining <= '0;
      op_q      <= OP_HOLD;
      data_q    <= '0;
      q_r       <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      wrap      <= wrap_nxt;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        if (cmd_op == OP_RSVD) err <= 1'b1;
      end
      if (run) q_r <= (J & ~q_r) | (~K & q_r);
    end
  end

endmodule
